// File: rtl/risc_test_sequencer.sv
// ---------------------------------------------------------------------------
// risc_test_sequencer
//
// On-chip self-test sequencer for the 5-stage RISC core. It runs NUM_PROG
// programs from a program ROM back to back. For each program it:
//   1. clears the whole register file through the shared RF port,
//   2. copies the program from ROM into instruction memory, stopping after
//      the HLT word or after MAX_LEN words,
//   3. releases the core reset and waits for HALTED, or gives up after
//      TIMEOUT cycles,
//   4. gives the core one cycle for its final writeback,
//   5. streams registers DUMP_FIRST..DUMP_FIRST+DUMP_COUNT-1 out on a
//      valid/ready port,
//   6. holds the core in reset for two cycles before the next program.
// This replaces hierarchical backdoor loads and dumps, so the same flow works
// on the board and in regression.
//
// Ports
//   clk_in       single clock (post-MMCM domain)
//   reset        asynchronous, active-low reset
//   start        pulse; begins a sequence, accepted only in IDLE/DONE
//   rom_addr     program ROM address (ROM answers one cycle later)
//   rom_data     program ROM data
//   imem_we/imem_addr/imem_wdata   instruction-memory write port
//   rf_sel       1 = register-file port owned by the sequencer
//   rf_we/rf_addr/rf_wdata         register-file write/read port (wdata = 0)
//   rf_rdata     register-file combinational read data
//   cpu_rst_n    core reset, active-low
//   cpu_halted   core HALTED flag (only looked at while running)
//   dump_valid/dump_ready/dump_data/dump_reg/dump_prog   register dump stream
//   busy         sequence in progress
//   done         all programs finished, held until the next start
//   timeout_err  sticky: at least one program hit TIMEOUT
// ---------------------------------------------------------------------------
module risc_test_sequencer #(
   parameter int DATA_W     = 32,
   parameter int IMEM_AW    = 10,
   parameter int REG_AW     = 5,
   parameter int NUM_PROG   = 2,
   parameter int MAX_LEN    = 16,
   parameter int DUMP_FIRST = 1,
   parameter int DUMP_COUNT = 5,
   parameter int TIMEOUT    = 4096,
   localparam int ROM_AW    = (NUM_PROG * MAX_LEN > 1) ? $clog2(NUM_PROG * MAX_LEN) : 1,
   localparam int PROG_W    = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                start,
   output logic [ROM_AW-1:0]   rom_addr,
   input  logic [DATA_W-1:0]   rom_data,
   output logic                imem_we,
   output logic [IMEM_AW-1:0]  imem_addr,
   output logic [DATA_W-1:0]   imem_wdata,
   output logic                rf_sel,
   output logic                rf_we,
   output logic [REG_AW-1:0]   rf_addr,
   output logic [DATA_W-1:0]   rf_wdata,
   input  logic [DATA_W-1:0]   rf_rdata,
   output logic                cpu_rst_n,
   input  logic                cpu_halted,
   output logic                dump_valid,
   input  logic                dump_ready,
   output logic [DATA_W-1:0]   dump_data,
   output logic [REG_AW-1:0]   dump_reg,
   output logic [PROG_W-1:0]   dump_prog,
   output logic                busy,
   output logic                done,
   output logic                timeout_err
);

   localparam int LEN_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int RUN_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int DCNT_W = (DUMP_COUNT > 1) ? $clog2(DUMP_COUNT) : 1;

   localparam logic [PROG_W-1:0]  LAST_PROG  = PROG_W'(NUM_PROG - 1);
   localparam logic [LEN_W-1:0]   LAST_WORD  = LEN_W'(MAX_LEN - 1);
   localparam logic [IMEM_AW-1:0] LAST_IADDR = IMEM_AW'(MAX_LEN - 1);
   localparam logic [RUN_W-1:0]   RUN_LIMIT  = RUN_W'(TIMEOUT - 1);
   localparam logic [DCNT_W-1:0]  LAST_DUMP  = DCNT_W'(DUMP_COUNT - 1);
   localparam logic [REG_AW-1:0]  FIRST_REG  = REG_AW'(DUMP_FIRST);
   localparam logic [5:0]         HLT_OP     = 6'h3F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_LOAD,
      S_RUN,
      S_SETTLE,
      S_DUMP,
      S_NEXT,
      S_DONE
   } state_t;

   state_t               state_reg;
   logic [PROG_W-1:0]    prog_reg;
   logic [LEN_W-1:0]     ld_idx_reg;     // offset of the ROM word requested this cycle
   logic [RUN_W-1:0]     run_cnt_reg;
   logic [DCNT_W-1:0]    dump_cnt_reg;
   logic                 next_cnt_reg;
   logic [ROM_AW-1:0]    rom_addr_reg;
   logic                 imem_we_reg;
   logic [IMEM_AW-1:0]   imem_addr_reg;
   logic                 rf_sel_reg;
   logic                 rf_we_reg;
   logic [REG_AW-1:0]    rf_addr_reg;
   logic                 cpu_rst_n_reg;
   logic                 dump_valid_reg;
   logic [DATA_W-1:0]    dump_data_reg;
   logic [REG_AW-1:0]    dump_reg_reg;
   logic [PROG_W-1:0]    dump_prog_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic                 timeout_err_reg;

   // The ROM answers one cycle after the address is issued, so the word
   // arriving this cycle goes straight to instruction memory. The write
   // strobe and address were registered one cycle earlier so that they line
   // up with it.
   logic                 load_is_hlt;
   logic                 load_is_last;
   logic [ROM_AW-1:0]    prog_base;

   assign load_is_hlt  = (rom_data[DATA_W-1 -: 6] == HLT_OP);
   assign load_is_last = (imem_addr_reg == LAST_IADDR);
   assign prog_base    = ROM_AW'(prog_reg) * ROM_AW'(MAX_LEN);

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_reg       <= S_IDLE;
         prog_reg        <= '0;
         ld_idx_reg      <= '0;
         run_cnt_reg     <= '0;
         dump_cnt_reg    <= '0;
         next_cnt_reg    <= 1'b0;
         rom_addr_reg    <= '0;
         imem_we_reg     <= 1'b0;
         imem_addr_reg   <= '0;
         rf_sel_reg      <= 1'b0;
         rf_we_reg       <= 1'b0;
         rf_addr_reg     <= '0;
         cpu_rst_n_reg   <= 1'b0;
         dump_valid_reg  <= 1'b0;
         dump_data_reg   <= '0;
         dump_reg_reg    <= '0;
         dump_prog_reg   <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            // A start in DONE also clears the previous run's status flags.
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_reg       <= S_CLR;
                  prog_reg        <= '0;
                  busy_reg        <= 1'b1;
                  done_reg        <= 1'b0;
                  timeout_err_reg <= 1'b0;
                  rf_sel_reg      <= 1'b1;
                  rf_we_reg       <= 1'b1;
                  rf_addr_reg     <= '0;
               end
            end

            // Zero one register per cycle over the whole register file.
            S_CLR: begin
               if (rf_addr_reg == {REG_AW{1'b1}}) begin
                  state_reg    <= S_LOAD;
                  rf_we_reg    <= 1'b0;
                  rf_sel_reg   <= 1'b0;
                  ld_idx_reg   <= '0;
                  imem_we_reg  <= 1'b0;
                  rom_addr_reg <= prog_base;
               end else begin
                  rf_addr_reg  <= rf_addr_reg + REG_AW'(1);
               end
            end

            // Each cycle requests the next ROM word while the word requested
            // one cycle earlier is written. Loading stops right after the HLT
            // word or the last slot is written. Requests past the end are
            // harmless because nothing writes them.
            S_LOAD: begin
               if (imem_we_reg && (load_is_hlt || load_is_last)) begin
                  state_reg     <= S_RUN;
                  imem_we_reg   <= 1'b0;
                  cpu_rst_n_reg <= 1'b1;
                  run_cnt_reg   <= '0;
               end else begin
                  imem_we_reg   <= 1'b1;
                  imem_addr_reg <= IMEM_AW'(ld_idx_reg);
                  if (ld_idx_reg != LAST_WORD) begin
                     ld_idx_reg   <= ld_idx_reg + LEN_W'(1);
                     rom_addr_reg <= rom_addr_reg + ROM_AW'(1);
                  end
               end
            end

            // A halt in the final allowed cycle still counts as a clean halt.
            S_RUN: begin
               if (cpu_halted) begin
                  state_reg <= S_SETTLE;
               end else if (run_cnt_reg == RUN_LIMIT) begin
                  state_reg       <= S_SETTLE;
                  timeout_err_reg <= 1'b1;
               end else begin
                  run_cnt_reg <= run_cnt_reg + RUN_W'(1);
               end
            end

            // The core stays out of reset one more cycle so that its last
            // writeback lands. Then the sequencer takes the RF port back.
            S_SETTLE: begin
               state_reg      <= S_DUMP;
               cpu_rst_n_reg  <= 1'b0;
               rf_sel_reg     <= 1'b1;
               rf_addr_reg    <= FIRST_REG;
               dump_cnt_reg   <= '0;
               dump_valid_reg <= 1'b0;
            end

            // Two phases per register. In the address phase (valid low)
            // rf_addr selects the register and its value is captured. In the
            // hold phase (valid high) the word waits for ready.
            S_DUMP: begin
               if (!dump_valid_reg) begin
                  dump_valid_reg <= 1'b1;
                  dump_data_reg  <= rf_rdata;
                  dump_reg_reg   <= rf_addr_reg;
                  dump_prog_reg  <= prog_reg;
               end else if (dump_ready) begin
                  dump_valid_reg <= 1'b0;
                  if (dump_cnt_reg == LAST_DUMP) begin
                     state_reg    <= S_NEXT;
                     rf_sel_reg   <= 1'b0;
                     next_cnt_reg <= 1'b0;
                  end else begin
                     dump_cnt_reg <= dump_cnt_reg + DCNT_W'(1);
                     rf_addr_reg  <= rf_addr_reg + REG_AW'(1);
                  end
               end
            end

            // The core has been in reset since the dump started. This adds
            // the two-cycle reset gap before the next program.
            S_NEXT: begin
               if (!next_cnt_reg) begin
                  next_cnt_reg <= 1'b1;
               end else begin
                  next_cnt_reg <= 1'b0;
                  if (prog_reg == LAST_PROG) begin
                     state_reg <= S_DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg   <= S_CLR;
                     prog_reg    <= prog_reg + PROG_W'(1);
                     rf_sel_reg  <= 1'b1;
                     rf_we_reg   <= 1'b1;
                     rf_addr_reg <= '0;
                  end
               end
            end

            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign rom_addr    = rom_addr_reg;
   assign imem_we     = imem_we_reg;
   assign imem_addr   = imem_addr_reg;
   assign imem_wdata  = rom_data;
   assign rf_sel      = rf_sel_reg;
   assign rf_we       = rf_we_reg;
   assign rf_addr     = rf_addr_reg;
   assign rf_wdata    = '0;
   assign cpu_rst_n   = cpu_rst_n_reg;
   assign dump_valid  = dump_valid_reg;
   assign dump_data   = dump_data_reg;
   assign dump_reg    = dump_reg_reg;
   assign dump_prog   = dump_prog_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_risc_test_sequencer.sv
// ---------------------------------------------------------------------------
// tb_risc_test_sequencer
//
// Bench for risc_test_sequencer with three programs: P0 and P1 end in HLT,
// P2 is sixteen words that never halt (TIMEOUT = 64). The bench models a
// program ROM, instruction memory, a register file and a stand-in core.
// When released, the stand-in core looks at imem[0] to tell which program
// was loaded. On its 3rd running cycle it writes known values into the
// register file. On its 4th cycle it starts raising HALTED, except for P2.
// The expected dump words go into a scoreboard queue before each start.
// A monitor pops one entry for every dump word that retires.
// ---------------------------------------------------------------------------
module tb_risc_test_sequencer;

   localparam int NP = 3;

   logic        clk_in;
   logic        reset;
   logic        start;
   logic [5:0]  rom_addr;
   logic [31:0] rom_data;
   logic        imem_we;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        rf_sel;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [31:0] rf_rdata;
   logic        cpu_rst_n;
   logic        cpu_halted;
   logic        dump_valid;
   logic        dump_ready;
   logic [31:0] dump_data;
   logic [4:0]  dump_reg;
   logic [1:0]  dump_prog;
   logic        busy;
   logic        done;
   logic        timeout_err;

   risc_test_sequencer #(
      .DATA_W(32), .IMEM_AW(10), .REG_AW(5), .NUM_PROG(NP), .MAX_LEN(16),
      .DUMP_FIRST(1), .DUMP_COUNT(5), .TIMEOUT(64)
   ) dut (
      .clk_in(clk_in), .reset(reset), .start(start),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .rf_sel(rf_sel), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
      .rf_rdata(rf_rdata), .cpu_rst_n(cpu_rst_n), .cpu_halted(cpu_halted),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
      .dump_reg(dump_reg), .dump_prog(dump_prog),
      .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int compared = 0;
   int mismatched = 0;

   logic [31:0] rom  [0:63];
   logic [31:0] imem [0:1023];
   logic [31:0] rf   [0:31];
   logic [31:0] snap [0:15][0:15];
   int          load_len [0:15];
   int          run_len  [0:15];
   int          run_idx = 0;
   logic        prefill = 1'b0;
   int          ready_mode = 0;
   logic [47:0] sb [$];

   assign rf_rdata = rf[rf_addr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] mk(input int p, input int r, input logic [31:0] d);
      return {8'(p), 8'(r), d};
   endfunction

   // Register values the stand-in core leaves in R1..R5 for each program.
   // Every register it does not write must read back as zero after the clear.
   function automatic logic [31:0] exp_reg(input int p, input int r);
      logic [31:0] v = 32'd0;
      if (p == 0) begin
         case (r)
            1: v = 32'd10;
            2: v = 32'd20;
            3: v = 32'd25;
            4: v = 32'd30;
            5: v = 32'd55;
            default: v = 32'd0;
         endcase
      end else if (p == 1 && r == 3) begin
         v = 32'd10;
      end else if (p == 2 && r == 5) begin
         v = 32'h1234;
      end
      return v;
   endfunction

   task automatic push_all();
      for (int p = 0; p < NP; p++)
         for (int r = 1; r <= 5; r++)
            sb.push_back(mk(p, r, exp_reg(p, r)));
   endtask

   // ROM, instruction memory, register file and stand-in core. The model
   // samples mid-cycle and drives its answers just after the next rising edge.
   initial begin
      int          core_cyc = 0;
      logic [31:0] nxt_rom = 32'd0;
      logic        nxt_halt = 1'b0;
      rom_data   = 32'd0;
      cpu_halted = 1'b0;
      forever begin
         @(negedge clk_in);
         nxt_rom = rom[rom_addr];
         if (imem_we) imem[imem_addr] = imem_wdata;
         if (imem_we) load_len[run_idx] = load_len[run_idx] + 1;
         if (rf_sel && rf_we) begin
            rf[rf_addr] = rf_wdata;
            if (rf_addr == 5'd0) load_len[run_idx] = 0;
         end
         if (prefill)
            for (int i = 0; i < 32; i++) rf[i] = 32'hBAD0_0000 | 32'(i);
         if (cpu_rst_n) begin
            if (core_cyc == 0)
               for (int k = 0; k < 16; k++) snap[run_idx][k] = imem[k];
            core_cyc++;
            if (core_cyc == 3) begin
               case (imem[0])
                  32'h2801000a: begin
                     rf[1] = 32'd10; rf[2] = 32'd20; rf[3] = 32'd25;
                     rf[4] = 32'd30; rf[5] = 32'd55;
                  end
                  32'h280A0005: rf[3] = 32'd10;
                  32'h3400FFFF: rf[5] = 32'h1234;
                  default: ;
               endcase
            end
            nxt_halt = (core_cyc >= 4) && (imem[0] != 32'h3400FFFF);
         end else begin
            if (core_cyc != 0) begin
               run_len[run_idx] = core_cyc;
               run_idx++;
            end
            core_cyc = 0;
            nxt_halt = 1'b0;
         end
         @(posedge clk_in);
         #1;
         rom_data   = nxt_rom;
         cpu_halted = nxt_halt;
      end
   end

   // Consumer: always ready, or ready on one cycle in three.
   initial begin
      int phase = 0;
      dump_ready = 1'b1;
      forever begin
         @(posedge clk_in);
         #1;
         phase = (phase + 1) % 3;
         dump_ready = (ready_mode == 0) ? 1'b1 : (phase == 0);
      end
   end

   // Scoreboard and hold-stability monitor.
   initial begin
      logic        prev_stall = 1'b0;
      logic [47:0] prev_word = '0;
      logic [47:0] cur;
      logic [47:0] exp;
      forever begin
         @(negedge clk_in);
         if (!reset) begin
            prev_stall = 1'b0;
         end else begin
            cur = {8'(dump_prog), 8'(dump_reg), dump_data};
            if (prev_stall)
               check("dump_hold", {15'd0, dump_valid, cur}, {15'd0, 1'b1, prev_word});
            if (dump_valid && dump_ready) begin
               $display("dump prog=%0d reg=%0d data=%0h", dump_prog, dump_reg, dump_data);
               if (sb.size() == 0) begin
                  compared++;
                  mismatched++;
                  $error("FAIL sb_underflow: observed %0h expected none", cur);
               end else begin
                  exp = sb.pop_front();
                  check("dump_word", 64'(cur), 64'(exp));
               end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_word  = cur;
         end
      end
   end

   task automatic pulse_start(input string tag);
      @(negedge clk_in);
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      $display("start %s", tag);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_done_clr"}, 64'(done), 64'd0);
      check({tag, "_terr_clr"}, 64'(timeout_err), 64'd0);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 3000) begin
         @(negedge clk_in);
         n++;
      end
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_terr"}, 64'(timeout_err), 64'd1);
      check({tag, "_idle"}, 64'(busy), 64'd0);
      check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
   endtask

   // Expected run lengths count cycles with the core out of reset (RUN plus
   // one SETTLE cycle). P0/P1 halt in RUN cycle 5, giving 6. P2 runs all 64
   // RUN cycles, giving 65.
   task automatic check_runs(input string tag, input int base);
      check({tag, "_run0"}, 64'(run_len[base]), 64'd6);
      check({tag, "_run1"}, 64'(run_len[base + 1]), 64'd6);
      check({tag, "_run2"}, 64'(run_len[base + 2]), 64'd65);
      check({tag, "_len0"}, 64'(load_len[base]), 64'd6);
      check({tag, "_len1"}, 64'(load_len[base + 1]), 64'd6);
      check({tag, "_len2"}, 64'(load_len[base + 2]), 64'd16);
      for (int k = 0; k < 6; k++) check({tag, "_imem0"}, 64'(snap[base][k]), 64'(rom[k]));
      for (int k = 0; k < 6; k++) check({tag, "_imem1"}, 64'(snap[base + 1][k]), 64'(rom[16 + k]));
      for (int k = 0; k < 16; k++) check({tag, "_imem2"}, 64'(snap[base + 2][k]), 64'(rom[32 + k]));
   endtask

   initial begin
      int base;
      int n;
      logic [31:0] p0 [0:5];
      logic [31:0] p1 [0:5];
      p0 = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h00222000, 32'h00832800, 32'hfc000000};
      p1 = '{32'h280A0005, 32'h280B0000, 32'h296B0002, 32'h294AFFFF, 32'h3540FFFD, 32'hFC000000};
      for (int i = 0; i < 16; i++) load_len[i] = 0;
      for (int i = 0; i < 16; i++) run_len[i] = 0;
      for (int i = 0; i < 64; i++) rom[i] = 32'hDEAD_BE00 | 32'(i);
      for (int i = 0; i < 6; i++) rom[i] = p0[i];
      for (int i = 0; i < 6; i++) rom[16 + i] = p1[i];
      for (int i = 0; i < 16; i++) rom[32 + i] = 32'h3400FFFF;
      reset = 1'b0;
      start = 1'b0;
      repeat (4) @(negedge clk_in);

      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_terr", 64'(timeout_err), 64'd0);
      check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      check("rst_rf_sel", 64'(rf_sel), 64'd0);
      check("rst_strobes", {61'd0, rf_we, imem_we, dump_valid}, 64'd0);

      prefill = 1'b1;
      repeat (2) @(negedge clk_in);
      prefill = 1'b0;
      reset = 1'b1;
      @(negedge clk_in);

      // Sequence 1: consumer always ready.
      ready_mode = 0;
      base = run_idx;
      push_all();
      pulse_start("seq1");
      wait_done("seq1");
      check_runs("seq1", base);

      // Sequence 2: restart from DONE, stalled consumer, stray start in RUN.
      ready_mode = 1;
      base = run_idx;
      push_all();
      pulse_start("seq2");
      n = 0;
      while (!cpu_rst_n && n < 2000) begin
         @(negedge clk_in);
         n++;
      end
      check("seq2_reach_run", 64'(cpu_rst_n), 64'd1);
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      @(negedge clk_in);
      check("seq2_stray_start_busy", 64'(busy), 64'd1);
      wait_done("seq2");
      check_runs("seq2", base);

      // Sequence 3: reset while word 3 is written, then a clean rerun.
      ready_mode = 0;
      push_all();
      pulse_start("seq3");
      n = 0;
      while (!(imem_we && imem_addr == 10'd3) && n < 2000) begin
         @(negedge clk_in);
         n++;
      end
      check("seq3_reach_word3", {63'd0, imem_we && imem_addr == 10'd3}, 64'd1);
      reset = 1'b0;
      #1;
      check("midrst_imem_we", 64'(imem_we), 64'd0);
      check("midrst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_rf_sel", 64'(rf_sel), 64'd0);
      sb.delete();
      @(negedge clk_in);
      reset = 1'b1;
      repeat (2) @(negedge clk_in);
      check("idle_after_rst", {62'd0, busy, done}, 64'd0);
      base = run_idx;
      push_all();
      pulse_start("seq4");
      wait_done("seq4");
      check_runs("seq4", base);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
